// File: rtl/dff_bank_ctrl.sv
// dff_bank_ctrl: two-requester round-robin controller for a WIDTH-bit register
// bank. The winning requester's command (CLEAR/PRESET/LOAD/SHIFT) and operand
// are latched at grant time and executed to completion, ending with a
// one-cycle done pulse.
//
// Ports:
//   clk            - clock, rising edge
//   clr            - asynchronous active-low reset
//   req[1:0]       - request from requester 0 (bit 0) / requester 1 (bit 1)
//   cmd0, cmd1     - per-requester command: 00 CLEAR, 01 PRESET, 10 LOAD, 11 SHIFT
//   data0, data1   - per-requester operand
//   gnt[1:0]       - one-hot grant, held from EXEC through DONE
//   done           - one-cycle completion pulse
//   busy           - high whenever the controller is not idle
//   q              - register bank contents
//   ser_out        - serial output, equal to q[0]
//   parity         - XOR of q; present only with DFF_BANK_CTRL_PARITY_EN defined
module dff_bank_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [1:0]       req,
  input  logic [1:0]       cmd0,
  input  logic [1:0]       cmd1,
  input  logic [WIDTH-1:0] data0,
  input  logic [WIDTH-1:0] data1,
  output logic [1:0]       gnt,
  output logic             done,
  output logic             busy,
  output logic [WIDTH-1:0] q,
  output logic             ser_out
`ifdef DFF_BANK_CTRL_PARITY_EN
  ,
  output logic             parity
`endif
);

  localparam int unsigned CNT_W = $clog2(WIDTH);

  localparam logic [1:0] CMD_CLEAR  = 2'b00;
  localparam logic [1:0] CMD_PRESET = 2'b01;
  localparam logic [1:0] CMD_LOAD   = 2'b10;
  localparam logic [1:0] CMD_SHIFT  = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_EXEC  = 2'b01,
    S_SHIFT = 2'b10,
    S_DONE  = 2'b11
  } state_t;

  state_t             state_q, state_d;
  logic [1:0]         gnt_q, gnt_d;
  logic [1:0]         cmd_q, cmd_d;
  logic [WIDTH-1:0]   data_q, data_d;
  logic [WIDTH-1:0]   q_q, q_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               prio_q, prio_d;
  logic               done_q, done_d;
  logic               busy_q, busy_d;
  logic               win_c;

  // State and datapath registers
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q <= S_IDLE;
      gnt_q   <= '0;
      cmd_q   <= '0;
      data_q  <= '0;
      q_q     <= '0;
      cnt_q   <= '0;
      prio_q  <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      cmd_q   <= cmd_d;
      data_q  <= data_d;
      q_q     <= q_d;
      cnt_q   <= cnt_d;
      prio_q  <= prio_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  // Next-state, arbitration and bank update
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    cmd_d   = cmd_q;
    data_d  = data_q;
    q_d     = q_q;
    cnt_d   = cnt_q;
    prio_d  = prio_q;

    // Sole requester wins outright; on contention prio_q names the winner.
    win_c = (req == 2'b11) ? prio_q : req[1];

    case (state_q)
      S_IDLE: begin
        gnt_d = '0;
        if (req != 2'b00) begin
          gnt_d   = win_c ? 2'b10 : 2'b01;
          cmd_d   = win_c ? cmd1 : cmd0;
          data_d  = win_c ? data1 : data0;
          prio_d  = ~win_c;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        state_d = S_DONE;
        case (cmd_q)
          CMD_CLEAR:  q_d = '0;
          CMD_PRESET: q_d = '1;
          CMD_LOAD:   q_d = data_q;
          CMD_SHIFT: begin
            cnt_d   = '0;
            state_d = S_SHIFT;
          end
          default:    q_d = q_q;
        endcase
      end
      S_SHIFT: begin
        // LSB-first insert at the top: after WIDTH shifts q equals data_q.
        q_d   = {data_q[cnt_q], q_q[WIDTH-1:1]};
        cnt_d = CNT_W'(cnt_q + 1'b1);
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        gnt_d   = '0;
      end
      default: state_d = S_IDLE;
    endcase

    done_d = (state_d == S_DONE);
    busy_d = (state_d != S_IDLE);
  end

  assign gnt     = gnt_q;
  assign done    = done_q;
  assign busy    = busy_q;
  assign q       = q_q;
  assign ser_out = q_q[0];

`ifdef DFF_BANK_CTRL_PARITY_EN
  assign parity = ^q_q;
`endif

endmodule
